// File: rtl/comparison_scheduler.sv
// Round-robin sequencer sharing one comparison unit between requesters A and B.
// Optional keep-grant locking is enabled by defining COMPARISON_LOCK_EN.
module comparison_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic [3:0] i_x_a,
  input  logic [3:0] i_y_a,
  input  logic [3:0] i_x_b,
  input  logic [3:0] i_y_b,
  input  logic [1:0] i_op_a,
  input  logic [1:0] i_op_b,
  input  logic       i_lock_a,
  input  logic       i_lock_b,
  output logic       o_ack_a,
  output logic       o_ack_b,
  output logic [7:0] o_result,
  output logic       o_result_valid,
  output logic       o_last_grant,
  output logic       o_busy,
  output logic [3:0] o_cmp_x,
  output logic [3:0] o_cmp_y,
  output logic [1:0] o_cmp_op,
  input  logic [7:0] i_cmp_result
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("comparison_scheduler: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] r_cnt;
  logic       r_last_grant;
  logic [3:0] r_cmp_x;
  logic [3:0] r_cmp_y;
  logic [1:0] r_cmp_op;
  logic [7:0] r_result;
  logic       r_result_valid;
  logic       w_grant;
  logic       w_pick_b;
  logic       w_capture;

`ifdef COMPARISON_LOCK_EN
  logic r_lock_valid;
  logic r_lock_owner;
`else
  logic w_unused_lock;
  assign w_unused_lock = i_lock_a ^ i_lock_b;
`endif

  // Arbitration: a live lock beats round-robin; otherwise ties go to the one not served last.
  always_comb begin
    w_pick_b = 1'b0;
    if (i_req_a && i_req_b) begin
      w_pick_b = ~r_last_grant;
    end else begin
      w_pick_b = i_req_b;
    end
`ifdef COMPARISON_LOCK_EN
    if (r_lock_valid && (r_lock_owner ? i_req_b : i_req_a)) begin
      w_pick_b = r_lock_owner;
    end
`endif
  end

  assign w_grant   = (r_state == StIdle) && (i_req_a || i_req_b);
  assign w_capture = (r_state == StDrive) && (r_cnt == 4'd0);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_grant) w_state_next = StDrive;
      StDrive: if (r_cnt == 4'd0) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs: r_last_grant always names the requester of the transaction in flight.
  always_comb begin
    o_ack_a = 1'b0;
    o_ack_b = 1'b0;
    o_busy  = 1'b0;
    if (r_state == StDone) begin
      o_ack_a = ~r_last_grant;
      o_ack_b = r_last_grant;
    end
    if (r_state != StIdle) begin
      o_busy = 1'b1;
    end
  end

  // Datapath: operands latched only at grant, result only at the end of the settle window.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt          <= 4'd0;
      r_last_grant   <= 1'b1;
      r_cmp_x        <= 4'd0;
      r_cmp_y        <= 4'd0;
      r_cmp_op       <= 2'b00;
      r_result       <= 8'h00;
      r_result_valid <= 1'b0;
    end else begin
      if (w_grant) begin
        r_cmp_x      <= w_pick_b ? i_x_b : i_x_a;
        r_cmp_y      <= w_pick_b ? i_y_b : i_y_a;
        r_cmp_op     <= w_pick_b ? i_op_b : i_op_a;
        r_last_grant <= w_pick_b;
        r_cnt        <= SettleLoad;
      end else if (w_capture) begin
        r_result       <= i_cmp_result;
        r_result_valid <= 1'b1;
      end else if (r_state == StDrive) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

`ifdef COMPARISON_LOCK_EN
  // Every grant rewrites the lock, which also covers release when the other side wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
    end else if (w_grant) begin
      r_lock_valid <= w_pick_b ? i_lock_b : i_lock_a;
      r_lock_owner <= w_pick_b;
    end
  end
`endif

  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_last_grant   = r_last_grant;
  assign o_cmp_x        = r_cmp_x;
  assign o_cmp_y        = r_cmp_y;
  assign o_cmp_op       = r_cmp_op;

endmodule

// File: tb/tb_comparison_scheduler.sv
// Scoreboard bench: two schedulers (settle 1 and 4) each driving a behavioural comparison unit.
module tb_comparison_scheduler;

  typedef struct {
    logic       who;
    logic [7:0] res;
    int         cyc;
  } exp_t;

  logic clk;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1;
  exp_t e4;

  logic       rst1, reqa1, reqb1, locka1, lockb1;
  logic [3:0] xa1, ya1, xb1, yb1;
  logic [1:0] opa1, opb1;
  logic       ack_a1, ack_b1, valid1, last1, busy1;
  logic [7:0] result1, cmp_res1;
  logic [3:0] cmp_x1, cmp_y1;
  logic [1:0] cmp_op1;

  logic       rst4, reqa4, reqb4, locka4, lockb4;
  logic [3:0] xa4, ya4, xb4, yb4;
  logic [1:0] opa4, opb4;
  logic       ack_a4, ack_b4, valid4, last4, busy4;
  logic [7:0] result4, cmp_res4;
  logic [3:0] cmp_x4, cmp_y4;
  logic [1:0] cmp_op4;

  function automatic logic [7:0] cmp_model(logic [3:0] x, logic [3:0] y, logic [1:0] op);
    case (op)
      2'b00:   return {7'd0, x == y};
      2'b01:   return {7'd0, x > y};
      2'b10:   return {7'd0, x < y};
      default: return {4'd0, (x > y) ? x : y};
    endcase
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  assign cmp_res1 = cmp_model(cmp_x1, cmp_y1, cmp_op1);
  assign cmp_res4 = cmp_model(cmp_x4, cmp_y4, cmp_op4);

  comparison_scheduler #(.SETTLE_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst1), .i_req_a(reqa1), .i_req_b(reqb1),
    .i_x_a(xa1), .i_y_a(ya1), .i_x_b(xb1), .i_y_b(yb1), .i_op_a(opa1), .i_op_b(opb1),
    .i_lock_a(locka1), .i_lock_b(lockb1), .o_ack_a(ack_a1), .o_ack_b(ack_b1),
    .o_result(result1), .o_result_valid(valid1), .o_last_grant(last1), .o_busy(busy1),
    .o_cmp_x(cmp_x1), .o_cmp_y(cmp_y1), .o_cmp_op(cmp_op1), .i_cmp_result(cmp_res1)
  );

  comparison_scheduler #(.SETTLE_CYCLES(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst4), .i_req_a(reqa4), .i_req_b(reqb4),
    .i_x_a(xa4), .i_y_a(ya4), .i_x_b(xb4), .i_y_b(yb4), .i_op_a(opa4), .i_op_b(opb4),
    .i_lock_a(locka4), .i_lock_b(lockb4), .o_ack_a(ack_a4), .o_ack_b(ack_b4),
    .o_result(result4), .o_result_valid(valid4), .o_last_grant(last4), .o_busy(busy4),
    .o_cmp_x(cmp_x4), .o_cmp_y(cmp_y4), .o_cmp_op(cmp_op4), .i_cmp_result(cmp_res4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: every ack pops one expectation and checks who, result, valid and arrival cycle.
  always @(negedge clk) begin
    if (ack_a1 || ack_b1) begin
      chk("dut1 acks exclusive", 32'(ack_a1 && ack_b1), 0);
      chk("dut1 ack expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("dut1 ack who", 32'(ack_b1), 32'(e1.who));
        chk("dut1 result", 32'(result1), 32'(e1.res));
        chk("dut1 result valid", 32'(valid1), 1);
        chk("dut1 ack cycle", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ack_a4 || ack_b4) begin
      chk("dut4 acks exclusive", 32'(ack_a4 && ack_b4), 0);
      chk("dut4 ack expected", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("dut4 ack who", 32'(ack_b4), 32'(e4.who));
        chk("dut4 result", 32'(result4), 32'(e4.res));
        chk("dut4 result valid", 32'(valid4), 1);
        chk("dut4 ack cycle", cyc, e4.cyc);
      end
    end
  end

  // Requesters drop req on the ack cycle; bounded so a missing ack cannot hang the run.
  task automatic run1(input int budget);
    for (int i = 0; i < budget && (reqa1 || reqb1); i++) begin
      @(negedge clk);
      if (ack_a1) reqa1 = 1'b0;
      if (ack_b1) reqb1 = 1'b0;
    end
    chk("dut1 transaction completes", 32'(reqa1 || reqb1), 0);
    reqa1 = 1'b0;
    reqb1 = 1'b0;
  endtask

  task automatic run4(input int budget);
    for (int i = 0; i < budget && (reqa4 || reqb4); i++) begin
      @(negedge clk);
      if (ack_a4) reqa4 = 1'b0;
      if (ack_b4) reqb4 = 1'b0;
    end
    chk("dut4 transaction completes", 32'(reqa4 || reqb4), 0);
    reqa4 = 1'b0;
    reqb4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acks;
    {reqa1, reqb1, locka1, lockb1, xa1, ya1, xb1, yb1, opa1, opb1} = '0;
    {reqa4, reqb4, locka4, lockb4, xa4, ya4, xb4, yb4, opa4, opb4} = '0;
    rst1 = 1'b1;
    rst4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    rst4 = 1'b0;

    chk("reset ack_a", 32'(ack_a1), 0);
    chk("reset ack_b", 32'(ack_b1), 0);
    chk("reset result", 32'(result1), 0);
    chk("reset result valid", 32'(valid1), 0);
    chk("reset last grant", 32'(last1), 1);
    chk("reset busy", 32'(busy1), 0);
    chk("reset cmp_x", 32'(cmp_x1), 0);
    chk("reset cmp_y", 32'(cmp_y1), 0);
    chk("reset cmp_op", 32'(cmp_op1), 0);

    // Single A request, settle 1: equal 5,5
    xa1 = 4'd5; ya1 = 4'd5; opa1 = 2'b00; reqa1 = 1'b1;
    q1.push_back(exp_t'{1'b0, 8'h01, cyc + 2});
    run1(20);
    chk("t1 cmp_x held", 32'(cmp_x1), 5);
    chk("t1 last grant", 32'(last1), 0);
    @(negedge clk);
    chk("t1 idle busy", 32'(busy1), 0);
    chk("t1 result held", 32'(result1), 32'h01);

    // Tie right after reset: A first, then B
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    xa1 = 4'd3; ya1 = 4'd9; opa1 = 2'b01;
    xb1 = 4'd3; yb1 = 4'd9; opb1 = 2'b11;
    reqa1 = 1'b1; reqb1 = 1'b1;
    q1.push_back(exp_t'{1'b0, 8'h00, cyc + 2});
    q1.push_back(exp_t'{1'b1, 8'h09, cyc + 5});
    run1(30);
    chk("t2 last grant", 32'(last1), 1);

    // Both held for six transactions: strict alternation, one every 3 cycles
    @(negedge clk);
    xa1 = 4'd7; ya1 = 4'd2; opa1 = 2'b01;
    xb1 = 4'd4; yb1 = 4'd10; opb1 = 2'b11;
    reqa1 = 1'b1; reqb1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      q1.push_back(exp_t'{k[0], k[0] ? 8'h0A : 8'h01, cyc + 2 + 3 * k});
    end
    acks = 0;
    for (int i = 0; i < 60 && acks < 6; i++) begin
      @(negedge clk);
      if (ack_a1 || ack_b1) acks++;
    end
    reqa1 = 1'b0; reqb1 = 1'b0;
    chk("t3 ack count", acks, 6);

    // Settle 4: B less-than, op changed mid-drive must be ignored
    xb4 = 4'd12; yb4 = 4'd7; opb4 = 2'b10; reqb4 = 1'b1;
    q4.push_back(exp_t'{1'b1, 8'h00, cyc + 5});
    repeat (2) @(negedge clk);
    opb4 = 2'b11; xb4 = 4'd0;
    chk("t4 cmp_op held", 32'(cmp_op4), 2);
    chk("t4 cmp_x held", 32'(cmp_x4), 12);
    chk("t4 busy in drive", 32'(busy4), 1);
    run4(20);

    @(negedge clk);
    xa4 = 4'd9; ya4 = 4'd4; opa4 = 2'b11; reqa4 = 1'b1;
    q4.push_back(exp_t'{1'b0, 8'h09, cyc + 5});
    run4(20);

    // Reset during DRIVE: no ack, result cleared
    @(negedge clk);
    xb4 = 4'd1; yb4 = 4'd1; opb4 = 2'b00; reqb4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5 busy before reset", 32'(busy4), 1);
    rst4 = 1'b1; reqb4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b0;
    chk("t5 result cleared", 32'(result4), 0);
    chk("t5 valid cleared", 32'(valid4), 0);
    chk("t5 busy cleared", 32'(busy4), 0);
    chk("t5 last grant reset", 32'(last4), 1);
    repeat (8) @(negedge clk);
    chk("t5 no stray ack", 32'(ack_a4 || ack_b4), 0);
    xa4 = 4'd2; ya4 = 4'd6; opa4 = 2'b10; reqa4 = 1'b1;
    q4.push_back(exp_t'{1'b0, 8'h01, cyc + 5});
    run4(20);

`ifdef COMPARISON_LOCK_EN
    // Lock: A keeps the grant for three transactions, then B
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    xa1 = 4'd1; ya1 = 4'd2; opa1 = 2'b10;
    xb1 = 4'd8; yb1 = 4'd3; opb1 = 2'b11;
    locka1 = 1'b1; reqa1 = 1'b1; reqb1 = 1'b1;
    q1.push_back(exp_t'{1'b0, 8'h01, cyc + 2});
    q1.push_back(exp_t'{1'b0, 8'h01, cyc + 5});
    q1.push_back(exp_t'{1'b0, 8'h01, cyc + 8});
    q1.push_back(exp_t'{1'b1, 8'h08, cyc + 11});
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge clk);
      if (ack_a1 || ack_b1) begin
        acks++;
        if (acks == 2) locka1 = 1'b0;
      end
    end
    reqa1 = 1'b0; reqb1 = 1'b0;
    chk("lock ack count", acks, 4);
    chk("lock last grant", 32'(last1), 1);
`endif

    repeat (3) @(negedge clk);
    chk("dut1 scoreboard drained", q1.size(), 0);
    chk("dut4 scoreboard drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
